// File: rtl/qnigma_pkg.sv
// Shared TCP types and sizing constants for the qnigma TX path.
package qnigma_pkg;

  localparam int TCP_TX_PACKET_DEPTH = 4;
  localparam int TCP_TX_FORCE_TICKS  = 1000;

  typedef struct packed {
    logic [31:0] loc_seq;
    logic [31:0] rem_ack;
    logic [15:0] mss;
  } tcb_t;

  typedef struct packed {
    logic        exists;
    logic [31:0] start;
    logic [31:0] stop;
    logic [15:0] lng;
    logic [15:0] cks;
    logic [7:0]  tries;
    logic        norm_rto;
    logic        sack_rto;
  } tcp_pkt_t;

  typedef enum logic [2:0] {
    ADD_IDLE,
    ADD_FILL,
    ADD_FOLD,
    ADD_PEND,
    ADD_WRITE
  } add_state_e;

endpackage

// File: rtl/qnigma_tcp_cks_acc.sv
// Byte-wise ones'-complement payload accumulator; each fold_i cycle applies one end-around carry.
module qnigma_tcp_cks_acc (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic        odd_i,
  input  logic [7:0]  byte_i,
  input  logic        fold_i,
  output logic [15:0] cks_o
);

  logic [31:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + (odd_i ? {24'd0, byte_i} : {16'd0, byte_i, 8'd0});
    end else if (fold_i) begin
      acc_d = {16'd0, acc_q[15:0]} + {16'd0, acc_q[31:16]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign cks_o = acc_q[15:0];

endmodule

// File: rtl/qnigma_tcp_tx_add.sv
// Packetises the user TX byte stream into TCP segments: payload to data RAM,
// one info RAM entry per segment, handshaken with the scan stage via add_pend.
module qnigma_tcp_tx_add
  import qnigma_pkg::*;
#(
  parameter int D_DEPTH     = 16,
  parameter int P_DEPTH     = TCP_TX_PACKET_DEPTH,
  parameter int FORCE_TICKS = TCP_TX_FORCE_TICKS
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  tcb_t               tcb_i,
  input  logic [7:0]         in_d_i,
  input  logic               in_v_i,
  input  logic               in_last_i,
  output logic               in_rdy_o,
  output logic [D_DEPTH-1:0] dram_a_o,
  output logic [7:0]         dram_d_o,
  output logic               dram_w_o,
  output logic [P_DEPTH-1:0] add_ptr_o,
  input  logic               ent_ex_i,
  output logic               add_o,
  output tcp_pkt_t           pkt_w_o,
  output logic               add_pend_o,
  input  logic               scan_upd_i
);

  localparam int              TW        = $clog2(FORCE_TICKS + 1);
  localparam logic [31:0]     RAM_FULL  = 32'((64'd1 << D_DEPTH) - 64'd1);
  localparam logic [TW-1:0]   TICK_LAST = TW'(FORCE_TICKS - 1);
  localparam logic [TW-1:0]   TICK_SAT  = TW'(FORCE_TICKS);

  add_state_e         state_q, state_d;
  logic               rd_ok_q, rd_ok_d;
  logic [31:0]        seq_nxt_q, seq_nxt_d;
  logic [31:0]        seg_start_q, seg_start_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [1:0]         step_q, step_d;
  logic [P_DEPTH-1:0] add_ptr_q, add_ptr_d;
  logic [D_DEPTH-1:0] dram_a_q;
  logic [7:0]         dram_d_q;
  logic               dram_w_q;

  logic [31:0] in_flight;
  logic        xfer, close, fold, acc_clr;
  logic [15:0] cks;

  qnigma_tcp_cks_acc u_cks (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (acc_clr),
    .add_i  (xfer),
    .odd_i  (cnt_q[0]),
    .byte_i (in_d_i),
    .fold_i (fold),
    .cks_o  (cks)
  );

  always_comb begin
    state_d     = state_q;
    rd_ok_d     = 1'b0;
    seq_nxt_d   = seq_nxt_q;
    seg_start_d = seg_start_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    step_d      = '0;
    add_ptr_d   = add_ptr_q;
    in_flight   = seq_nxt_q - tcb_i.rem_ack;
    in_rdy_o    = 1'b0;
    xfer        = 1'b0;
    close       = 1'b0;
    fold        = 1'b0;
    acc_clr     = 1'b0;
    add_o       = 1'b0;
    add_pend_o  = 1'b0;
    pkt_w_o     = '0;
    unique case (state_q)
      // ent_ex arrives one cycle after add_ptr settles, so the first IDLE cycle only waits.
      ADD_IDLE: begin
        rd_ok_d = 1'b1;
        if (rd_ok_q && !ent_ex_i) begin
          rd_ok_d     = 1'b0;
          seg_start_d = seq_nxt_q;
          state_d     = ADD_FILL;
        end
      end
      ADD_FILL: begin
        in_rdy_o = (in_flight < RAM_FULL);
        xfer     = in_v_i && in_rdy_o;
        if (xfer) begin
          seq_nxt_d = seq_nxt_q + 32'd1;
          cnt_d     = cnt_q + 16'd1;
          timer_d   = '0;
          close     = (cnt_d == tcb_i.mss) || in_last_i;
        end else if (cnt_q != 16'd0) begin
          // Closes on the FORCE_TICKS-th idle clock after the last byte.
          close = (timer_q == TICK_LAST);
          if (timer_q != TICK_SAT) timer_d = timer_q + TW'(1);
        end
        if (close) begin
          timer_d = '0;
          state_d = ADD_FOLD;
        end
      end
      ADD_FOLD: begin
        fold   = 1'b1;
        step_d = step_q + 2'd1;
        if (step_q == 2'd1) begin
          step_d  = '0;
          state_d = ADD_PEND;
        end
      end
      ADD_PEND: begin
        add_pend_o = 1'b1;
        step_d     = step_q + 2'd1;
        if (step_q == 2'd2) begin
          step_d = step_q;
          if (!scan_upd_i) begin
            step_d  = '0;
            state_d = ADD_WRITE;
          end
        end
      end
      ADD_WRITE: begin
        add_o          = 1'b1;
        add_pend_o     = 1'b1;
        pkt_w_o.exists = 1'b1;
        pkt_w_o.start  = seg_start_q;
        pkt_w_o.stop   = seq_nxt_q - 32'd1;
        pkt_w_o.lng    = cnt_q;
        pkt_w_o.cks    = cks;
        add_ptr_d      = add_ptr_q + P_DEPTH'(1);
        cnt_d          = '0;
        acc_clr        = 1'b1;
        state_d        = ADD_IDLE;
      end
      default: state_d = ADD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ADD_IDLE;
      rd_ok_q     <= 1'b0;
      seq_nxt_q   <= tcb_i.loc_seq;
      seg_start_q <= tcb_i.loc_seq;
      cnt_q       <= '0;
      timer_q     <= '0;
      step_q      <= '0;
      add_ptr_q   <= '0;
      dram_a_q    <= '0;
      dram_d_q    <= '0;
      dram_w_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ok_q     <= rd_ok_d;
      seq_nxt_q   <= seq_nxt_d;
      seg_start_q <= seg_start_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      step_q      <= step_d;
      add_ptr_q   <= add_ptr_d;
      dram_w_q    <= xfer;
      if (xfer) begin
        dram_a_q <= seq_nxt_q[D_DEPTH-1:0];
        dram_d_q <= in_d_i;
      end
    end
  end

  assign dram_a_o  = dram_a_q;
  assign dram_d_o  = dram_d_q;
  assign dram_w_o  = dram_w_q;
  assign add_ptr_o = add_ptr_q;

endmodule
